// File: rtl/ladybird_axi_pkg.sv
// Shared AXI encodings for the ladybird bus: burst types, response codes
// and the AxSIZE helper used by initiators.
package ladybird_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef logic [1:0] axi_resp_t;

  // AxSIZE encoding is log2 of the beat width in bytes.
  function automatic logic [2:0] size_of_bytes(input int unsigned nbytes);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (nbytes >= (32'd1 << i)) s = 3'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/ladybird_axi_interface.sv
// Ladybird AXI bundle (no ID return channels); master drives requests,
// slave drives ready/response signals.
interface ladybird_axi_interface #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_ID_W   = 4
);

  logic [AXI_ID_W-1:0]     arid;
  logic [AXI_ADDR_W-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic                    arvalid;
  logic                    arready;

  logic [AXI_DATA_W-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  logic [AXI_ID_W-1:0]     awid;
  logic [AXI_ADDR_W-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic                    awvalid;
  logic                    awready;

  logic [AXI_DATA_W-1:0]   wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/ladybird_axi_master.sv
// Cache-line AXI initiator: turns one line read/write request into a single
// INCR burst and reports completion with an accumulated error flag.
module ladybird_axi_master
  import ladybird_axi_pkg::*;
#(
  parameter int LINE_W     = 128,
  parameter int AXI_ID     = 0,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_ID_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [AXI_ADDR_W-1:0]   req_addr,
  input  logic [LINE_W-1:0]       req_wdata,
  input  logic [LINE_W/8-1:0]     req_wstrb,
  output logic                    resp_valid,
  output logic                    resp_we,
  output logic [LINE_W-1:0]       resp_data,
  output logic                    resp_error,
  ladybird_axi_interface.master   axi
);

  localparam int BEATS  = LINE_W / AXI_DATA_W;
  localparam int STRB_W = AXI_DATA_W / 8;
  localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]      CNT_END   = CNT_W'(BEATS);
  localparam logic [AXI_ADDR_W-1:0] LINE_MASK = AXI_ADDR_W'(LINE_W / 8 - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_AR   = 3'd1;
  localparam logic [2:0] ST_R    = 3'd2;
  localparam logic [2:0] ST_AW   = 3'd3;
  localparam logic [2:0] ST_W    = 3'd4;
  localparam logic [2:0] ST_B    = 3'd5;
  localparam logic [2:0] ST_RESP = 3'd6;

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  we_q;
  logic [AXI_ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0]     resp_data_q;
  logic [AXI_DATA_W-1:0] data_q [BEATS];
  logic [STRB_W-1:0]     strb_q [BEATS];
  logic [LINE_W-1:0]     rd_line;
  logic [IDX_W-1:0]      idx;
  logic                  req_fire;
  logic                  r_fire;

  assign idx      = cnt_q[IDX_W-1:0];
  assign req_fire = (state_q == ST_IDLE) && req_valid;
  assign r_fire   = (state_q == ST_R) && axi.rvalid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        err_d = 1'b0;
        if (req_valid) state_d = req_we ? ST_AW : ST_AR;
      end
      ST_AR: if (axi.arready) state_d = ST_R;
      ST_R: begin
        if (axi.rvalid) begin
          // rlast must coincide exactly with the final expected beat.
          if (axi.rresp != RESP_OKAY) err_d = 1'b1;
          if (axi.rlast != (cnt_q == CNT_LAST)) err_d = 1'b1;
          if (cnt_q < CNT_END) cnt_d = cnt_q + 1'b1;
          if (axi.rlast) state_d = ST_RESP;
        end
      end
      ST_AW: if (axi.awready) state_d = ST_W;
      ST_W: begin
        if (axi.wready) begin
          if (cnt_q == CNT_LAST) state_d = ST_B;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_B: begin
        if (axi.bvalid) begin
          if (axi.bresp != RESP_OKAY) err_d = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Merge the incoming beat into the buffered line so the completed read
  // can be published in one step.
  always_comb begin
    rd_line = '0;
    for (int b = 0; b < BEATS; b++) begin
      rd_line[b*AXI_DATA_W +: AXI_DATA_W] = (cnt_q == CNT_W'(b)) ? axi.rdata : data_q[b];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      resp_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (req_fire) begin
        we_q   <= req_we;
        addr_q <= req_addr & ~LINE_MASK;
      end
      if (r_fire && axi.rlast) resp_data_q <= rd_line;
    end
  end

  // Line buffer: holds write beats, then collects read beats.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      for (int b = 0; b < BEATS; b++) begin
        data_q[b] <= req_wdata[b*AXI_DATA_W +: AXI_DATA_W];
        strb_q[b] <= req_wstrb[b*STRB_W +: STRB_W];
      end
    end else if (r_fire && (cnt_q < CNT_END)) begin
      data_q[idx] <= axi.rdata;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_we    = we_q;
  assign resp_error = err_q;
  assign resp_data  = resp_data_q;

  assign axi.arid    = AXI_ID_W'(AXI_ID);
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 8'(BEATS - 1);
  assign axi.arsize  = size_of_bytes(STRB_W);
  assign axi.arburst = BURST_INCR;
  assign axi.arlock  = 1'b0;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.arqos   = 4'd0;
  assign axi.arvalid = (state_q == ST_AR);
  assign axi.rready  = (state_q == ST_R);

  assign axi.awid    = AXI_ID_W'(AXI_ID);
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 8'(BEATS - 1);
  assign axi.awsize  = size_of_bytes(STRB_W);
  assign axi.awburst = BURST_INCR;
  assign axi.awlock  = 1'b0;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.awqos   = 4'd0;
  assign axi.awvalid = (state_q == ST_AW);

  assign axi.wvalid  = (state_q == ST_W);
  assign axi.wdata   = data_q[idx];
  assign axi.wstrb   = strb_q[idx];
  assign axi.wlast   = (cnt_q == CNT_LAST);
  assign axi.bready  = (state_q == ST_B);

endmodule

// File: tb/tb_ladybird_axi_master.sv
// Directed + randomized bench for ladybird_axi_master against a byte-level
// memory responder and a reference byte image of the same memory.
module tb_ladybird_axi_master;

  localparam int LINE_W = 128;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BEATS  = LINE_W / DATA_W;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [127:0]  req_wdata = '0;
  logic [15:0]   req_wstrb = '0;
  logic          resp_valid;
  logic          resp_we;
  logic [127:0]  resp_data;
  logic          resp_error;

  ladybird_axi_interface #(.AXI_ADDR_W(ADDR_W), .AXI_DATA_W(DATA_W), .AXI_ID_W(4)) axi ();

  ladybird_axi_master #(
    .LINE_W(LINE_W), .AXI_ID(0), .AXI_ADDR_W(ADDR_W), .AXI_DATA_W(DATA_W), .AXI_ID_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_we(resp_we), .resp_data(resp_data),
    .resp_error(resp_error), .axi(axi)
  );

  always #5 clk = ~clk;

  logic [7:0] mem    [256];
  logic [7:0] refMem [256];

  int testsRun  = 0;
  int failCount = 0;

  // responder configuration
  int        arDelay = 0, awDelay = 0;
  bit        rGap = 0, wGap = 0, wStall = 0;
  int        slverrBeat = -1, earlyLastBeat = -1;
  logic [1:0] brespVal = 2'b00;

  // responder bookkeeping
  int stableErrs = 0, wlastErrs = 0, wOrderErrs = 0;
  logic [31:0] gotAraddr, gotAwaddr;
  logic [7:0]  gotArlen, gotAwlen;
  logic [2:0]  gotArsize, gotAwsize;
  logic [1:0]  gotArburst, gotAwburst;
  logic [3:0]  gotArid;
  logic [127:0] lastData;

  // Memory responder: commits the previous cycle's handshakes at each
  // falling edge, then drives this cycle's ready/valid/payload.
  initial begin : responder
    bit rdActive, wrActive, bPend;
    bit arHs, rHs, awHs, wHs, bHs, rLastDriven;
    bit lastArv, lastAwv, lastWv;
    logic [31:0] lastAra, lastAwa, lastWd, cWdata, rdAddr, wrAddr;
    logic [3:0]  cWstrb;
    bit cWlast;
    int rdBeat, rdLen, wrBeat, wrLen, arWait, awWait, off;
    rdActive = 0; wrActive = 0; bPend = 0;
    arHs = 0; rHs = 0; awHs = 0; wHs = 0; bHs = 0; rLastDriven = 0;
    lastArv = 0; lastAwv = 0; lastWv = 0;
    lastAra = '0; lastAwa = '0; lastWd = '0; cWdata = '0; cWstrb = '0; cWlast = 0;
    rdAddr = '0; wrAddr = '0; rdBeat = 0; rdLen = 0; wrBeat = 0; wrLen = 0;
    arWait = 0; awWait = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        rdActive = 0; wrActive = 0; bPend = 0;
        arHs = 0; rHs = 0; awHs = 0; wHs = 0; bHs = 0;
        lastArv = 0; lastAwv = 0; lastWv = 0; arWait = 0; awWait = 0;
        axi.arready = 0; axi.rvalid = 0; axi.rlast = 0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
        continue;
      end
      if (lastArv && !arHs && (!axi.arvalid || axi.araddr !== lastAra)) stableErrs++;
      if (lastAwv && !awHs && (!axi.awvalid || axi.awaddr !== lastAwa)) stableErrs++;
      if (lastWv && !wHs && (!axi.wvalid || axi.wdata !== lastWd)) stableErrs++;
      if (arHs) begin
        rdActive = 1; rdAddr = axi.araddr; rdLen = int'(axi.arlen) + 1; rdBeat = 0; arWait = 0;
        gotAraddr = axi.araddr; gotArlen = axi.arlen; gotArsize = axi.arsize;
        gotArburst = axi.arburst; gotArid = axi.arid;
      end
      if (rHs) begin
        rdBeat++;
        if (rLastDriven) rdActive = 0;
      end
      if (awHs) begin
        wrActive = 1; wrAddr = axi.awaddr; wrLen = int'(axi.awlen) + 1; wrBeat = 0; awWait = 0;
        gotAwaddr = axi.awaddr; gotAwlen = axi.awlen; gotAwsize = axi.awsize; gotAwburst = axi.awburst;
      end
      if (wHs) begin
        off = int'((wrAddr - BASE) & 32'hFF) + 4 * wrBeat;
        for (int k = 0; k < 4; k++) if (cWstrb[k]) mem[(off + k) & 255] = cWdata[8*k +: 8];
        if (cWlast != (wrBeat == wrLen - 1)) wlastErrs++;
        wrBeat++;
        if (cWlast) begin wrActive = 0; bPend = 1; end
      end
      if (bHs) bPend = 0;
      if (axi.wvalid && !wrActive) wOrderErrs++;

      if (axi.arvalid && !rdActive) begin
        if (arWait >= arDelay) axi.arready = 1;
        else begin axi.arready = 0; arWait++; end
      end else axi.arready = 0;
      if (rdActive && !(rGap && $urandom_range(0, 2) == 0)) begin
        off = int'((rdAddr - BASE) & 32'hFF) + 4 * rdBeat;
        axi.rvalid = 1;
        axi.rdata  = {mem[(off+3)&255], mem[(off+2)&255], mem[(off+1)&255], mem[off&255]};
        axi.rresp  = (rdBeat == slverrBeat) ? 2'b10 : 2'b00;
        axi.rlast  = (rdBeat == rdLen - 1) || (rdBeat == earlyLastBeat);
      end else begin
        axi.rvalid = 0; axi.rlast = 0;
      end
      if (axi.awvalid && !wrActive && !bPend) begin
        if (awWait >= awDelay) axi.awready = 1;
        else begin axi.awready = 0; awWait++; end
      end else axi.awready = 0;
      axi.wready = wrActive && !wStall && !(wGap && $urandom_range(0, 2) == 0);
      axi.bvalid = bPend;
      axi.bresp  = brespVal;

      arHs = axi.arvalid && axi.arready;
      rHs  = axi.rvalid && axi.rready; rLastDriven = axi.rlast;
      awHs = axi.awvalid && axi.awready;
      wHs  = axi.wvalid && axi.wready;
      cWdata = axi.wdata; cWstrb = axi.wstrb; cWlast = axi.wlast;
      bHs  = axi.bvalid && axi.bready;
      lastArv = axi.arvalid; lastAra = axi.araddr;
      lastAwv = axi.awvalid; lastAwa = axi.awaddr;
      lastWv  = axi.wvalid;  lastWd  = axi.wdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    testsRun++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [127:0] wdata,
                               input logic [15:0] wstrb, output int latency, output logic [127:0] data,
                               output bit err, output bit rwe, output bit readyInResp,
                               output bit pulseOk, output bit timedOut);
    int waitCnt;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb; req_valid = 1'b1;
    waitCnt = 0;
    while (!req_ready && waitCnt < 50) begin @(negedge clk); waitCnt++; end
    @(negedge clk);
    req_valid = 1'b0;
    latency = 1;
    while (!resp_valid && latency < 400) begin @(negedge clk); latency++; end
    timedOut = !resp_valid;
    data = resp_data; err = resp_error; rwe = resp_we; readyInResp = req_ready;
    @(negedge clk);
    pulseOk = !resp_valid && req_ready;
  endtask

  task automatic runCheck(input string tag, input bit we, input logic [31:0] addr,
                          input logic [127:0] wdata, input logic [15:0] wstrb,
                          input bit checkLat, input int expLat, input bit checkData);
    int lat, off;
    logic [127:0] data, expLine, memLine;
    bit err, rwe, rdyResp, pulseOk, tmo, expErr;
    logic [31:0] aligned;
    aligned = addr & ~32'hF;
    off = int'(addr[7:0]) & 8'hF0;
    if (we) expErr = (brespVal != 2'b00);
    else    expErr = (slverrBeat >= 0 && slverrBeat < BEATS) ||
                     (earlyLastBeat >= 0 && earlyLastBeat < BEATS - 1);
    applyStimulus(we, addr, wdata, wstrb, lat, data, err, rwe, rdyResp, pulseOk, tmo);
    lastData = data;
    checkOutput({tag, " timeout"}, 128'(tmo), 128'(0));
    if (checkLat) checkOutput({tag, " latency"}, 128'(lat), 128'(expLat));
    checkOutput({tag, " resp_error"}, 128'(err), 128'(expErr));
    checkOutput({tag, " resp_we"}, 128'(rwe), 128'(we));
    checkOutput({tag, " req_ready in RESP"}, 128'(rdyResp), 128'(0));
    checkOutput({tag, " single pulse"}, 128'(pulseOk), 128'(1));
    checkOutput({tag, " payload stable"}, 128'(stableErrs), 128'(0));
    if (we) begin
      for (int b = 0; b < 16; b++) if (wstrb[b]) refMem[off + b] = wdata[8*b +: 8];
      for (int b = 0; b < 16; b++) begin
        expLine[8*b +: 8] = refMem[off + b];
        memLine[8*b +: 8] = mem[off + b];
      end
      checkOutput({tag, " memory line"}, memLine, expLine);
      checkOutput({tag, " awaddr"}, 128'(gotAwaddr), 128'(aligned));
      checkOutput({tag, " awlen/awsize/awburst"}, 128'({gotAwlen, gotAwsize, gotAwburst}),
                  128'({8'd3, 3'd2, 2'b01}));
      checkOutput({tag, " wlast"}, 128'(wlastErrs), 128'(0));
      checkOutput({tag, " W before AW"}, 128'(wOrderErrs), 128'(0));
    end else begin
      for (int b = 0; b < 16; b++) expLine[8*b +: 8] = refMem[off + b];
      checkOutput({tag, " araddr"}, 128'(gotAraddr), 128'(aligned));
      checkOutput({tag, " arlen/arsize/arburst/arid"}, 128'({gotArlen, gotArsize, gotArburst, gotArid}),
                  128'({8'd3, 3'd2, 2'b01, 4'd0}));
      if (checkData) checkOutput({tag, " resp_data"}, data, expLine);
    end
  endtask

  initial begin : stimulus
    logic [31:0] addr;
    logic [127:0] wd;
    logic [15:0] ws;
    bit sawResp;
    int waitCnt;
    for (int i = 0; i < 256; i++) begin
      mem[i] = (i < 16) ? 8'(i) : 8'($urandom);
      refMem[i] = mem[i];
    end

    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset req_ready", 128'(req_ready), 128'(1));
    checkOutput("reset resp_valid", 128'(resp_valid), 128'(0));
    checkOutput("reset resp_error", 128'(resp_error), 128'(0));
    checkOutput("reset resp_data", resp_data, 128'(0));
    checkOutput("reset axi valids", 128'({axi.arvalid, axi.awvalid, axi.wvalid}), 128'(0));
    checkOutput("reset axi readies", 128'({axi.rready, axi.bready}), 128'(0));
    @(posedge clk);
    #2 rst = 1'b0;

    runCheck("read line0", 1'b0, BASE, '0, '0, 1'b1, 2 + BEATS, 1'b1);
    checkOutput("read line0 constant", lastData, 128'h0F0E0D0C_0B0A0908_07060504_03020100);

    runCheck("write unaligned", 1'b1, BASE + 32'h14, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA,
             16'hFFF0, 1'b0, 0, 1'b0);
    checkOutput("write unaligned awaddr const", 128'(gotAwaddr), 128'(32'h8000_0010));
    runCheck("readback line1", 1'b0, BASE + 32'h18, '0, '0, 1'b1, 2 + BEATS, 1'b1);

    arDelay = 5; awDelay = 5; rGap = 1; wGap = 1;
    for (int n = 0; n < 10; n++) begin
      addr = BASE + 32'($urandom_range(0, 15) * 16) + 32'($urandom_range(0, 15));
      wd = {$urandom, $urandom, $urandom, $urandom};
      ws = 16'($urandom);
      runCheck($sformatf("random %0d", n), 1'($urandom_range(0, 1)), addr, wd, ws, 1'b0, 0, 1'b1);
    end
    arDelay = 0; awDelay = 0; rGap = 0; wGap = 0;

    slverrBeat = 2;
    runCheck("read slverr", 1'b0, BASE + 32'h20, '0, '0, 1'b1, 2 + BEATS, 1'b1);
    slverrBeat = -1;
    runCheck("read after slverr", 1'b0, BASE + 32'h30, '0, '0, 1'b1, 2 + BEATS, 1'b1);

    brespVal = 2'b11;
    runCheck("write decerr", 1'b1, BASE + 32'h40, {$urandom, $urandom, $urandom, $urandom},
             16'hFFFF, 1'b0, 0, 1'b0);
    brespVal = 2'b00;
    runCheck("write after decerr", 1'b1, BASE + 32'h50, {$urandom, $urandom, $urandom, $urandom},
             16'h0F0F, 1'b0, 0, 1'b0);

    earlyLastBeat = 1;
    runCheck("early rlast", 1'b0, BASE + 32'h60, '0, '0, 1'b1, 2 + 2, 1'b0);
    earlyLastBeat = -1;
    runCheck("read after early rlast", 1'b0, BASE + 32'h70, '0, '0, 1'b1, 2 + BEATS, 1'b1);

    // Abort a write in its data phase; stalled wready keeps memory untouched.
    wStall = 1;
    @(negedge clk);
    req_we = 1'b1; req_addr = BASE + 32'h80; req_wdata = {4{32'h5A5A_5A5A}}; req_wstrb = 16'hFFFF;
    req_valid = 1'b1;
    waitCnt = 0;
    while (!req_ready && waitCnt < 50) begin @(negedge clk); waitCnt++; end
    @(negedge clk);
    req_valid = 1'b0;
    waitCnt = 0;
    while (!axi.wvalid && waitCnt < 50) begin @(negedge clk); waitCnt++; end
    checkOutput("abort reached W", 128'(axi.wvalid), 128'(1));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort wvalid/awvalid drop", 128'({axi.wvalid, axi.awvalid}), 128'(0));
    checkOutput("abort req_ready in reset", 128'(req_ready), 128'(1));
    @(posedge clk);
    #2 rst = 1'b0;
    wStall = 0;
    sawResp = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (resp_valid) sawResp = 1;
    end
    checkOutput("abort no resp_valid", 128'(sawResp), 128'(0));
    checkOutput("abort req_ready after release", 128'(req_ready), 128'(1));
    runCheck("read after abort", 1'b0, BASE + 32'h80, '0, '0, 1'b1, 2 + BEATS, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
